// File: rtl/imem_loader.sv
// imem_loader: streams a program image into instruction memory over a
// valid/ready byte interface. One registered write per accepted byte at
// consecutive addresses from BASE_ADDR. The CPU is held off during a load
// and after an overflowed load.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no load since reset; waiting for start
// LOAD   | accepting bytes, CPU held
// DONE   | last load completed; CPU released one cycle after entry
// ERR    | last load overflowed memory; CPU held until reset or start
module imem_loader #(
  parameter int unsigned MEM_BYTES = 1025,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  input  logic        in_last,
  output logic        in_ready,
  output logic        mem_wEn,
  output logic [63:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        load_err,
  output logic [10:0] byte_count,
  output logic [7:0]  checksum
);

  localparam logic [63:0] BASE      = 64'(BASE_ADDR);
  localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 1);
  localparam logic [10:0] CNT_MAX   = 11'(MEM_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;

  state_t      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [10:0] cnt_q, cnt_d;
  logic [7:0]  cks_q, cks_d;
  logic        wen_q, wen_d;
  logic [63:0] waddr_q, waddr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        hold_q, hold_d;
  logic        accept;

  assign in_ready = (state_q == S_LOAD);
  assign accept   = in_valid & in_ready;

  // Next-state, write-register and statistics update.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    cks_d   = cks_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_LOAD: begin
        if (accept) begin
          wen_d   = 1'b1;
          waddr_d = addr_q;
          wdata_d = in_byte;
          addr_d  = addr_q + 64'd1;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 11'd1;
          cks_d = cks_q ^ in_byte;
          // in_last wins over overflow: a program that exactly fills memory is valid.
          if (in_last)                state_d = S_DONE;
          else if (addr_q == LAST_ADDR) state_d = S_ERR;
        end
      end
      default: begin
        if (start) begin
          state_d = S_LOAD;
          addr_d  = BASE;
          cnt_d   = '0;
          cks_d   = '0;
        end
      end
    endcase
    // Hold stays up for the cycle the final write lands, so fetch never
    // sees a partially written image.
    hold_d = (state_d == S_LOAD) || (state_d == S_ERR) ||
             ((state_q == S_LOAD) && (state_d == S_DONE));
  end

  // State and output registers; reset drops any pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      cks_q   <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      cks_q   <= cks_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
    end
  end

  assign mem_wEn    = wen_q;
  assign mem_addr   = waddr_q;
  assign mem_data   = wdata_q;
  assign cpu_hold   = hold_q;
  assign done       = (state_q == S_DONE);
  assign load_err   = (state_q == S_ERR);
  assign byte_count = cnt_q;
  assign checksum   = cks_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that is the write-side counterpart of the fetch stage's instruction memory read port. Accepts a byte stream over a valid/ready handshake and issues one registered byte write per accepted byte to the instruction memory write port (`mem_wEn`/`mem_addr`/`mem_data`), at consecutive addresses starting at `BASE_ADDR`. While loading, and after a failed load, it holds the processor off with `cpu_hold`. It reports completion, overflow error, byte count and a running XOR checksum.

## Interface
- `MEM_BYTES`, 1025: instruction memory depth in bytes; legal write addresses are 0..MEM_BYTES-1.
- `BASE_ADDR`, 0: address of the first byte written in each load.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse to begin a load; honoured only in IDLE, DONE or ERR.
- `in_valid`  in  1  source presents `in_byte`.
- `in_byte`  in  8  program byte.
- `in_last`  in  1  marks the final byte of the program; qualified by `in_valid`.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `mem_wEn`  out  1  write strobe to instruction memory, one cycle per byte.
- `mem_addr`  out  64  byte address of the write.
- `mem_data`  out  8  byte to write.
- `cpu_hold`  out  1  stalls fetch/PC while asserted.
- `done`  out  1  last load completed successfully.
- `load_err`  out  1  last load overflowed memory.
- `byte_count`  out  11  bytes accepted in the current/last load.
- `checksum`  out  8  XOR of all bytes accepted in the current/last load.

## Operation
- States: IDLE, LOAD, DONE, ERR. Reset → IDLE.
- Accept condition: `in_valid & in_ready`. `in_ready` = 1 only in LOAD.
- IDLE:
  - `start` → LOAD.
  - On entering LOAD from any state: `addr` = BASE_ADDR, `byte_count` = 0, `checksum` = 0, `done` = 0, `load_err` = 0.
- LOAD, on each accepted byte:
  - Capture `{addr, in_byte}` into the write register; `addr` += 1; `byte_count` += 1; `checksum` ^= `in_byte`.
  - If `in_last` → DONE.
  - Else if `addr` == MEM_BYTES-1 (the byte just accepted filled the last location) → ERR. That byte is still written.
  - `start` in LOAD is ignored.
- DONE: `done` = 1, `cpu_hold` = 0. `start` → new load. Inputs are otherwise ignored.
- ERR: `load_err` = 1, `cpu_hold` = 1, so the CPU never runs a truncated image. `start` → new load; only `reset` or `start` leave ERR.
- `BASE_ADDR` ≥ MEM_BYTES is a configuration error. Behaviour in that case is not required.
- Widths:
  - `addr` is 64 bits and never wraps; the overflow check prevents reaching MEM_BYTES.
  - `byte_count` saturates at MEM_BYTES (11 bits suffice for 1025).

## Timing
- Reset values: `in_ready`=0, `mem_wEn`=0, `mem_addr`=0, `mem_data`=0, `cpu_hold`=0, `done`=0, `load_err`=0, `byte_count`=0, `checksum`=0.
- `start` in cycle N: LOAD from N+1, `in_ready`=1 and `cpu_hold`=1 in N+1.
- Byte accepted in cycle N:
  - `mem_wEn`=1 with its `mem_addr`/`mem_data` in cycle N+1 (registered, latency 1).
  - `byte_count`/`checksum` updated in N+1.
- Throughput: 1 byte/cycle; back-to-back accepts give contiguous `mem_wEn` pulses.
- `in_valid` low: no write and no state change.
- Last byte accepted in N:
  - `done`=1 in N+1, coincident with the final `mem_wEn`.
  - `cpu_hold` stays 1 in N+1 and drops in N+2, so fetch never sees a partial image.
- Overflow byte accepted in N: final write and `load_err`=1 in N+1; `cpu_hold` stays 1.
- `reset` in any cycle, including LOAD with a write pending: all outputs take reset values next cycle and the pending write is dropped (`mem_wEn`=0).
- `in_last` on the byte that also fills the last location: success (DONE), not ERR.

## Test plan
- Basic load: reset, start, stream 0x30,0xF4,0x0E,0x00 with in_last on the 4th → writes at addr 0..3 with those bytes on cycles start+2..start+5; done=1 with byte_count=4, checksum=0xCA; cpu_hold drops one cycle after done rises.
- Bubbles: same stream with in_valid low every other cycle → identical writes; no mem_wEn in gap cycles; byte_count=4.
- Exact fill: stream 1025 bytes of 0x01, in_last on byte 1025 → last write at addr 1024; done=1; load_err=0; byte_count=1025; checksum=0x01.
- Overflow: 1025 bytes, none marked last → write at 1024 occurs; load_err=1; in_ready=0; cpu_hold stays 1; byte 1026 not accepted.
- Reset mid-load: accept 3 bytes, assert reset in the cycle the 3rd is accepted → no write for the 3rd byte; all outputs 0 next cycle; start then reloads from addr 0 with count reset.
- Restart/ignore: start during LOAD has no effect on addr; start in DONE clears done, byte_count and checksum, and rewrites from BASE_ADDR.
